axis_rr_arbiter: RTL
====================

# axis_rr_arbiter

Two-input AXI-Stream arbiter that shares one 8-bit downstream stream consumer, such as the `axis_sink` checker or a DMA write port, between two stream producers. Grants are round-robin at burst granularity: once a requester is granted, it keeps the output for exactly BURST accepted beats, and the arbiter marks the final beat with TLAST. The block sits between producer-side DMA/source engines and the shared consumer in the stream-based simulation and test fabric.

## Interface
Parameters:
- BURST, 8: beats per grant; legal range 1..255.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- S0_AXIS_TVALID  in  1  requester 0 valid.
- S0_AXIS_TDATA  in  8  requester 0 data.
- S0_AXIS_TREADY  out  1  requester 0 ready.
- S1_AXIS_TVALID  in  1  requester 1 valid.
- S1_AXIS_TDATA  in  8  requester 1 data.
- S1_AXIS_TREADY  out  1  requester 1 ready.
- M_AXIS_TVALID  out  1  shared output valid.
- M_AXIS_TDATA  out  8  shared output data.
- M_AXIS_TLAST  out  1  high on the BURST-th beat of the current grant.
- M_AXIS_TID  out  1  index of the granted requester.
- M_AXIS_TREADY  in  1  downstream ready.
- busy  out  1  high while in the GRANT state.
- bursts_done  out  16  count of completed bursts; wraps at 65535 -> 0.

## Operation
- Two states: IDLE and GRANT. Registers: `sel` (1 bit), `rr_ptr` (1 bit, preferred requester), `beat_cnt` (8 bits), `bursts_done`.
- In IDLE:
  - If only one requester has TVALID=1, load `sel` with that index and go to GRANT.
  - If both have TVALID=1, load `sel` = `rr_ptr` and go to GRANT.
  - If neither has TVALID=1, stay in IDLE.
  - In every case, clear `beat_cnt` to 0.
- In GRANT, the datapath is combinational:
  - M_AXIS_TVALID = S[sel].TVALID; M_AXIS_TDATA = S[sel].TDATA.
  - S[sel].TREADY = M_AXIS_TREADY; the non-selected TREADY = 0.
  - M_AXIS_TID = sel.
  - M_AXIS_TLAST = (beat_cnt == BURST-1) && M_AXIS_TVALID.
- A beat is accepted when M_AXIS_TVALID && M_AXIS_TREADY.
  - Each accepted beat increments `beat_cnt`.
  - On the accepted beat with beat_cnt == BURST-1: go to IDLE, set rr_ptr = ~sel, and increment bursts_done.
- The grant is locked for the whole burst. If the granted requester drops TVALID mid-burst, the arbiter holds the grant and waits; no preemption and no timeout.
- In IDLE:
  - M_AXIS_TVALID, M_AXIS_TLAST, both TREADYs and busy are 0.
  - M_AXIS_TDATA = 0 and M_AXIS_TID = sel (last grant).
- `beat_cnt` is 8 bits wide and never exceeds BURST-1.

## Timing
- Reset (rst_n=0 sampled at a clock edge) forces the following at the next edge, including mid-burst:
  - state=IDLE, sel=0, rr_ptr=0, beat_cnt=0, bursts_done=0.
  - All outputs therefore read 0.
  - Beats that were partially delivered are abandoned; no TLAST is emitted for them.
- Grant latency: a request seen in IDLE at edge N makes the output valid in the cycle after edge N. The earliest first beat is accepted at edge N+1.
- Every burst costs one IDLE bubble cycle before the next grant. Peak throughput is therefore BURST/(BURST+1) beats per cycle.
- If requests arrive simultaneously with rr_ptr=0, the order is S0, S1, S0, ... .
- A lone requester may be granted back-to-back, with a one-cycle bubble between its bursts.
- A requester that asserts TVALID during the other's burst waits; it is granted at the IDLE cycle that follows.
- Within a grant, the output obeys AXIS rules by construction: data and valid come straight from the granted source, which must hold them stable until accepted.

## Test plan
- Case 1, S0 alone, BURST=8:
  - Stimulus: S0 sends 0..7 with M_AXIS_TREADY=1.
  - Required: the output carries 0..7 with TID=0; TLAST only on 7; one idle cycle after the burst; bursts_done=1.
- Case 2, both requesters continuously valid:
  - Stimulus: S0 sends 0x00.., S1 sends 0x80...
  - Required: bursts alternate S0, S1, S0, S1; each burst is 8 contiguous values; after 4 bursts, bursts_done=4.
- Case 3, downstream backpressure (`axis_sink` stall pattern, ready low 2 of every 8 cycles), both requesters active, 32 beats total:
  - Required: no beat lost or duplicated; the non-granted TREADY is never high; the sink error flag stays 0.
- Case 4, S0 drops TVALID for 5 cycles after beat 3 while S1 is requesting:
  - Required: the grant stays on S0 and S1 TREADY=0 throughout; the burst completes with 4 more beats; then S1 is granted.
- Case 5, reset pulled low for one cycle after beat 3 of a burst:
  - Required: at the next edge, busy=0, M_AXIS_TVALID=0 and bursts_done=0.
  - Required: with both requesting afterward, S0 is granted first.
- Case 6, BURST=1:
  - Required: every beat has TLAST=1, and requests alternate every 2 cycles.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// Two-input AXI-Stream round-robin arbiter; each grant is locked for BURST accepted beats.
module axis_rr_arbiter #(
    parameter int unsigned BURST = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        S0_AXIS_TVALID,
    input  logic [7:0]  S0_AXIS_TDATA,
    output logic        S0_AXIS_TREADY,
    input  logic        S1_AXIS_TVALID,
    input  logic [7:0]  S1_AXIS_TDATA,
    output logic        S1_AXIS_TREADY,
    output logic        M_AXIS_TVALID,
    output logic [7:0]  M_AXIS_TDATA,
    output logic        M_AXIS_TLAST,
    output logic        M_AXIS_TID,
    input  logic        M_AXIS_TREADY,
    output logic        busy,
    output logic [15:0] bursts_done
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned BD_W  = 16;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic             sel;
    logic             sel_nxt;
    logic             rr_ptr;
    logic             rr_ptr_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beat_cnt_nxt;
    logic [BD_W-1:0]  bursts_done_nxt;
    logic             mvalid_c;

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            sel         <= 1'b0;
            rr_ptr      <= 1'b0;
            beat_cnt    <= '0;
            bursts_done <= '0;
        end else begin
            state       <= state_nxt;
            sel         <= sel_nxt;
            rr_ptr      <= rr_ptr_nxt;
            beat_cnt    <= beat_cnt_nxt;
            bursts_done <= bursts_done_nxt;
        end
    end

    // Arbitration, burst counting and the combinational datapath mux.
    always_comb begin
        state_nxt       = state;
        sel_nxt         = sel;
        rr_ptr_nxt      = rr_ptr;
        beat_cnt_nxt    = beat_cnt;
        bursts_done_nxt = bursts_done;
        mvalid_c        = 1'b0;
        M_AXIS_TVALID   = 1'b0;
        M_AXIS_TDATA    = '0;
        M_AXIS_TLAST    = 1'b0;
        M_AXIS_TID      = sel;
        S0_AXIS_TREADY  = 1'b0;
        S1_AXIS_TREADY  = 1'b0;
        busy            = 1'b0;

        case (state)
            ST_IDLE: begin
                beat_cnt_nxt = '0;
                if (S0_AXIS_TVALID && S1_AXIS_TVALID) begin
                    sel_nxt   = rr_ptr;
                    state_nxt = ST_GRANT;
                end else if (S0_AXIS_TVALID) begin
                    sel_nxt   = 1'b0;
                    state_nxt = ST_GRANT;
                end else if (S1_AXIS_TVALID) begin
                    sel_nxt   = 1'b1;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                busy           = 1'b1;
                mvalid_c       = sel ? S1_AXIS_TVALID : S0_AXIS_TVALID;
                M_AXIS_TVALID  = mvalid_c;
                M_AXIS_TDATA   = sel ? S1_AXIS_TDATA : S0_AXIS_TDATA;
                S0_AXIS_TREADY = !sel && M_AXIS_TREADY;
                S1_AXIS_TREADY = sel && M_AXIS_TREADY;
                M_AXIS_TLAST   = (beat_cnt == LAST_IDX) && mvalid_c;
                if (mvalid_c && M_AXIS_TREADY) begin
                    if (beat_cnt == LAST_IDX) begin
                        state_nxt       = ST_IDLE;
                        rr_ptr_nxt      = !sel;
                        beat_cnt_nxt    = '0;
                        bursts_done_nxt = bursts_done + BD_W'(1);
                    end else begin
                        beat_cnt_nxt = beat_cnt + CNT_W'(1);
                    end
                end
            end
        endcase
    end

endmodule
